// File: rtl/mult_div_unit.sv
// Sequential signed 32-bit multiply/divide unit.
// A start pulse latches the operands. An iterative engine then runs for 32 cycles,
// and the result, exception flag and a one-cycle ready strobe come out on a shared
// output bus.
//
// Handshake: there is no backpressure. A start pulse on ctrl_MULT or ctrl_DIV
// that is sampled on a rising edge is always accepted, even in the middle of an
// operation (the current operation is abandoned). data_resultRDY is high for
// exactly one cycle, 32 edges after the last start edge. data_result and
// data_exception are valid in that cycle and hold until the next start edge.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  count;
  logic        mode_mult;

  // Multiplier: unsigned shift-add on the operand magnitudes. The sign is applied at the end.
  logic [63:0] mul_acc;
  logic [63:0] mul_mcand;
  logic [31:0] mul_mplier;
  logic        mul_neg;

  // Divider: restoring division on the magnitudes. The quotient is built up in div_quo.
  logic [32:0] div_rem;
  logic [31:0] div_quo;
  logic [31:0] div_dvsr;
  logic        div_neg;
  logic        div_exc;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] mul_acc_nxt;
  logic [63:0] mul_prod;
  logic        mul_ovf;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [32:0] div_rem_nxt;
  logic [31:0] div_quo_nxt;
  logic [31:0] div_q;
  logic [31:0] fin_result;
  logic        fin_exc;
  logic        start;

  assign dbg_state = state;
  assign start     = ctrl_MULT | ctrl_DIV;

  // Operand magnitudes, plus one iteration step of each engine and the final result formatting.
  always_comb begin
    a_mag       = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    b_mag       = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    mul_acc_nxt = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
    mul_prod    = mul_neg ? (~mul_acc_nxt + 64'd1) : mul_acc_nxt;
    // The product fits in signed 32 bits only when bits 63..31 are all copies of the sign bit.
    mul_ovf     = !((&mul_prod[63:31]) || !(|mul_prod[63:31]));

    div_shift   = {div_rem[31:0], div_quo[31]};
    div_ge      = (div_shift >= {1'b0, div_dvsr});
    div_rem_nxt = div_ge ? (div_shift - {1'b0, div_dvsr}) : div_shift;
    div_quo_nxt = {div_quo[30:0], div_ge};
    div_q       = div_neg ? (~div_quo_nxt + 32'd1) : div_quo_nxt;

    if (mode_mult) begin
      fin_result = mul_prod[31:0];
      fin_exc    = mul_ovf;
    end else begin
      fin_result = div_exc ? 32'd0 : div_q;
      fin_exc    = div_exc;
    end
  end

  // Control FSM, engine iteration and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      count          <= 5'd0;
      mode_mult      <= 1'b0;
      mul_acc        <= 64'd0;
      mul_mcand      <= 64'd0;
      mul_mplier     <= 32'd0;
      mul_neg        <= 1'b0;
      div_rem        <= 33'd0;
      div_quo        <= 32'd0;
      div_dvsr       <= 32'd0;
      div_neg        <= 1'b0;
      div_exc        <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (start) begin
      // Multiply wins when both strobes are high.
      state          <= BUSY;
      count          <= 5'd0;
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        mode_mult  <= 1'b1;
        mul_acc    <= 64'd0;
        mul_mcand  <= {32'd0, a_mag};
        mul_mplier <= b_mag;
        mul_neg    <= data_operandA[31] ^ data_operandB[31];
      end else begin
        mode_mult <= 1'b0;
        div_rem   <= 33'd0;
        div_quo   <= a_mag;
        div_dvsr  <= b_mag;
        div_neg   <= data_operandA[31] ^ data_operandB[31];
        div_exc   <= (data_operandB == 32'd0) ||
                     ((data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF));
      end
    end else begin
      case (state)
        BUSY: begin
          if (mode_mult) begin
            mul_acc    <= mul_acc_nxt;
            mul_mcand  <= {mul_mcand[62:0], 1'b0};
            mul_mplier <= {1'b0, mul_mplier[31:1]};
          end else begin
            div_rem <= div_rem_nxt;
            div_quo <= div_quo_nxt;
          end
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state          <= DONE;
            data_result    <= fin_result;
            data_exception <= fin_exc;
            data_resultRDY <= 1'b1;
          end
        end
        DONE: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit. A behavioural model (plain 64-bit arithmetic and a
// countdown to the result) is checked against the outputs on every falling edge.
// Directed cases with literal expectations pin down the model.
module tb_mult_div_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int fails   = 0;

  mult_div_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .dbg_state      (dbg_state)
  );

  // Clock and reset.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  int          m_count = 0;
  logic [31:0] m_res   = '0;
  logic        m_exc   = 1'b0;
  logic        m_rdy   = 1'b0;
  logic [31:0] p_res   = '0;
  logic        p_exc   = 1'b0;

  function automatic void model_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
    longint p;
    int sa, sb;
    sa = a;
    sb = b;
    if (is_mult) begin
      p = longint'(sa) * longint'(sb);
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      r = sa / sb;
      e = 1'b0;
    end
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_count = 0;
      m_res   = '0;
      m_exc   = 1'b0;
      m_rdy   = 1'b0;
    end else begin
      m_rdy = 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        model_op(ctrl_MULT, data_operandA, data_operandB, p_res, p_exc);
        m_count = 32;
      end else if (m_count > 0) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_rdy = 1'b1;
          m_res = p_res;
          m_exc = p_exc;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are registered, so they are checked on every falling edge.
  always @(negedge clock) begin
    chk("rdy", 64'(data_resultRDY), 64'(m_rdy));
    chk("result", 64'(data_result), 64'(m_res));
    chk("exception", 64'(data_exception), 64'(m_exc));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic start_op(input bit is_mult, input bit both, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
    ctrl_MULT     = is_mult | both;
    ctrl_DIV      = !is_mult | both;
    data_operandA = a;
    data_operandB = b;
    repeat (hold) tick();
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic run_dir(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_e, input string name);
    int n;
    start_op(is_mult, 1'b0, a, b, 1);
    n = 0;
    while (n < 40 && !data_resultRDY) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'd32);
    chk({name, "_result"}, 64'(data_result), 64'(exp_r));
    chk({name, "_exc"}, 64'(data_exception), 64'(exp_e));
    tick();
    chk({name, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 200)) - 32'd100;
      6: return 32'($urandom_range(0, 65535));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n_rdy;
    int k;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) tick();
    chk("reset_result", 64'(data_result), 64'd0);
    chk("reset_exc", 64'(data_exception), 64'd0);
    chk("reset_rdy", 64'(data_resultRDY), 64'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    run_dir(1'b1, 32'd3, 32'd4, 32'd12, 1'b0, "mul_3x4");
    run_dir(1'b1, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, "mul_m7x6");
    run_dir(1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, "mul_ovf");
    run_dir(1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "mul_min_x1");
    run_dir(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_xm1");
    run_dir(1'b0, 32'hFFFF_FFD5, 32'd5, 32'hFFFF_FFF8, 1'b0, "div_m43_5");
    run_dir(1'b0, 32'd7, 32'd0, 32'd0, 1'b1, "div_by0");
    run_dir(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "div_ovf");
    run_dir(1'b0, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, "div_min_2");
    run_dir(1'b0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div_100_m7");

    // Hold after DONE: outputs stay put until the next start.
    repeat (5) tick();
    chk("hold_result", 64'(data_result), 64'hFFFF_FFF2);

    // Reset in flight: no RDY may ever appear for the discarded multiply.
    start_op(1'b1, 1'b0, 32'd9, 32'd9, 1);
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_flight_result", 64'(data_result), 64'd0);
    chk("rst_flight_exc", 64'(data_exception), 64'd0);
    chk("rst_flight_rdy", 64'(data_resultRDY), 64'd0);
    tick();
    reset_n = 1'b1;
    n_rdy = 0;
    repeat (45) begin
      tick();
      if (data_resultRDY) n_rdy++;
    end
    chk("rst_flight_no_rdy", 64'(n_rdy), 64'd0);

    // Abort: a divide restarted as a multiply after 5 cycles gives exactly one RDY.
    start_op(1'b0, 1'b0, 32'd50, 32'd3, 1);
    repeat (4) tick();
    start_op(1'b1, 1'b0, 32'd2, 32'd5, 1);
    n_rdy = 0;
    k = 0;
    for (int i = 1; i <= 45; i++) begin
      if (data_resultRDY) begin
        n_rdy++;
        if (k == 0) k = i - 1;
      end
      tick();
    end
    chk("abort_rdy_count", 64'(n_rdy), 64'd1);
    chk("abort_latency", 64'(k), 64'd32);
    chk("abort_result", 64'(data_result), 64'd10);

    // Randomized traffic, with aborts, both-strobe starts and held starts.
    for (int i = 0; i < 250; i++) begin
      int kind;
      int hold;
      kind = $urandom_range(0, 9);
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 4) : 1;
      start_op(kind < 5, kind == 9, pick_operand(), pick_operand(), hold);
      repeat ($urandom_range(0, 38)) tick();
    end
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
